// File: rtl/hamming_encoder_7_4.sv
// rtl/hamming_encoder_7_4.sv - registered Hamming(7,4) encoder with 1- or 2-stage pipeline
module hamming_encoder_7_4 #(
    parameter int PIPE_STAGES = 1
) (
    input  logic       clk,
    input  logic       rst_n,      // asynchronous, active-high despite the name
    input  logic       ena,
    input  logic [3:0] data_in,
    output logic [6:0] code_out,
    output logic       valid_out
);

    generate
        if (PIPE_STAGES != 1 && PIPE_STAGES != 2) begin : g_bad_pipe_stages
            $error("hamming_encoder_7_4: PIPE_STAGES must be 1 or 2");
        end
    endgenerate

    // Codeword positions 7..1 = {d3,d2,d1,p3,d0,p2,p1}
    function automatic logic [6:0] encode(input logic [3:0] d);
        logic p1;
        logic p2;
        logic p3;
        p1 = d[0] ^ d[1] ^ d[3];
        p2 = d[0] ^ d[2] ^ d[3];
        p3 = d[1] ^ d[2] ^ d[3];
        return {d[3], d[2], d[1], p3, d[0], p2, p1};
    endfunction

    logic [PIPE_STAGES-1:0]      valid_q;
    logic [PIPE_STAGES-1:0]      valid_d;
    logic [PIPE_STAGES-1:0][6:0] code_q;
    logic [PIPE_STAGES-1:0][6:0] code_d;

    // Stage 0 encodes on acceptance and otherwise holds its code so that an idle
    // (possibly undriven) data_in never reaches code_out; later stages just delay.
    always_comb begin
        valid_d    = '0;
        code_d     = code_q;
        valid_d[0] = ena;
        code_d[0]  = ena ? encode(data_in) : code_q[0];
        for (int i = 1; i < PIPE_STAGES; i++) begin
            valid_d[i] = valid_q[i-1];
            code_d[i]  = code_q[i-1];
        end
    end

    // Pipeline registers; reset discards every word in flight.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            valid_q <= '0;
            code_q  <= '0;
        end else begin
            valid_q <= valid_d;
            code_q  <= code_d;
        end
    end

    assign code_out  = code_q[PIPE_STAGES-1];
    assign valid_out = valid_q[PIPE_STAGES-1];

endmodule

// File: tb/tb_hamming_encoder_7_4.sv
// tb/tb_hamming_encoder_7_4.sv - scoreboard testbench for hamming_encoder_7_4
module tb_hamming_encoder_7_4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       ena = 1'b0;
    logic [3:0] data_in = 4'h0;
    logic [6:0] code_out;
    logic       valid_out;

    int tests = 0;
    int fails = 0;

    logic [6:0] exp_q[$];
    logic [6:0] last_code = 7'h00;
    logic [6:0] rx_code[16];
    int         rx_n = 0;
    bit         capture = 1'b0;

    // Hand-computed codewords for nibbles 0..F
    logic [6:0] exp_tab[16] = '{7'h00, 7'h07, 7'h19, 7'h1E, 7'h2A, 7'h2D, 7'h33, 7'h34,
                                7'h4B, 7'h4C, 7'h52, 7'h55, 7'h61, 7'h66, 7'h78, 7'h7F};

    hamming_encoder_7_4 #(.PIPE_STAGES(1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .data_in   (data_in),
        .code_out  (code_out),
        .valid_out (valid_out)
    );

    always #5 clk = ~clk;

    // Monitor: pops and checks on every valid cycle, checks hold on idle cycles
    always @(negedge clk) begin
        if (rst_n) begin
            last_code = 7'h00;
        end else if (valid_out) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_valid: code_out=%h with no word expected", code_out);
            end else begin
                logic [6:0] e;
                e = exp_q.pop_front();
                if (code_out !== e) begin
                    fails++;
                    $display("FAIL codeword: got %h expected %h", code_out, e);
                end
            end
            if (capture && rx_n < 16) begin
                rx_code[rx_n] = code_out;
                rx_n++;
            end
            last_code = code_out;
        end else begin
            tests++;
            if (code_out !== last_code) begin
                fails++;
                $display("FAIL hold: code_out=%h expected held %h", code_out, last_code);
            end
        end
    end

    task automatic send(input logic e, input logic [3:0] d);
        ena     = e;
        data_in = d;
        if (e) exp_q.push_back(exp_tab[d]);
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        ena = 1'b0;
        while (exp_q.size() != 0 && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        @(posedge clk);
        #1;
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d words never appeared, expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        logic [3:0] single[5];
        single = '{4'h0, 4'h1, 4'h8, 4'hB, 4'hF};

        // Power-on reset, then release mid-cycle
        repeat (2) @(posedge clk);
        #1;
        tests++;
        if (code_out !== 7'h00 || valid_out !== 1'b0) begin
            fails++;
            $display("FAIL reset_state: code=%h valid=%b expected 00/0", code_out, valid_out);
        end
        rst_n = 1'b0;

        // Prime a nonzero codeword, then assert reset mid-cycle
        send(1'b1, 4'hF);
        drain();
        #2;
        rst_n = 1'b1;
        #1;
        tests++;
        if (code_out !== 7'h00 || valid_out !== 1'b0) begin
            fails++;
            $display("FAIL async_reset: code=%h valid=%b expected 00/0", code_out, valid_out);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b0;

        // Single words with idle cycles between
        for (int i = 0; i < 5; i++) begin
            send(1'b1, single[i]);
            send(1'b0, 4'h0);
            send(1'b0, 4'h0);
        end
        drain();

        // Streaming 0..F back-to-back
        capture = 1'b1;
        for (int i = 0; i < 16; i++) send(1'b1, 4'(i));
        drain();
        capture = 1'b0;
        tests++;
        if (rx_n != 16) begin
            fails++;
            $display("FAIL stream_count: got %0d words expected 16", rx_n);
        end

        // Alternating ena with random data, idle data random too
        for (int i = 0; i < 12; i++) begin
            send(1'b1, 4'($urandom_range(0, 15)));
            send(1'b0, 4'($urandom_range(0, 15)));
        end
        drain();

        // Reset mid-stream: discard in-flight word, then first sample after release
        send(1'b1, 4'h6);
        send(1'b1, 4'h9);
        rst_n = 1'b1;
        exp_q.delete();
        #1;
        tests++;
        if (valid_out !== 1'b0) begin
            fails++;
            $display("FAIL midstream_reset: valid=%b expected 0", valid_out);
        end
        ena = 1'b1;
        data_in = 4'hC;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        send(1'b1, 4'h5);
        drain();

        // Single-bit error syndrome on every received codeword
        for (int w = 0; w < rx_n; w++) begin
            for (int b = 0; b < 7; b++) begin
                logic [6:0] cw;
                logic [2:0] syn;
                cw = rx_code[w] ^ (7'h01 << b);
                syn = 3'd0;
                for (int p = 1; p <= 7; p++) if (cw[p-1]) syn = syn ^ 3'(p);
                tests++;
                if (syn != 3'(b + 1)) begin
                    fails++;
                    $display("FAIL syndrome: word %0d bit %0d got %0d expected %0d", w, b, syn, b + 1);
                end
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
